uart_tx_fifo: RTL and testbench
===============================

# uart_tx_fifo

Transmit-side byte buffer between the Wishbone UART register interface and the serial transmitter. Bus writes to the TX data register are queued into a DEPTH-entry FIFO. A small launch state machine hands the bytes to the transmitter one at a time: it pulses `send_o` with stable data, then waits for the transmitter's `end_char_tx` pulse before launching the next byte. Software can therefore write a burst of characters without polling between them.

## Interface

Parameters:
- `DEPTH`, 16: FIFO entries; must be a power of two, at least 2.
- `AW`, 4: pointer width; must equal log2(DEPTH).

Ports:
- `clk_i`  in  1  system clock (wb.clk).
- `rst_i`  in  1  reset (wb.rst); asynchronous, active-high.
- `wr_i`  in  1  one-cycle write strobe from the bus decode (stb & we & sel[3] & adr[2]==0).
- `wdata_i`  in  8  byte to enqueue; sampled when `wr_i`=1.
- `clear_i`  in  1  synchronous flush of the FIFO plus clear of `overflow_o`.
- `end_char_tx_i`  in  1  one-cycle pulse from the transmitter when the stop bit completes.
- `send_o`  out  1  one-cycle launch pulse to the transmitter.
- `tx_data_o`  out  8  byte being transmitted; stable from `send_o` until `end_char_tx_i`.
- `full_o`  out  1  level == DEPTH.
- `empty_o`  out  1  level == 0.
- `idle_o`  out  1  FIFO empty and no character in flight; drives the status bits tx_empty.
- `level_o`  out  AW+1  number of queued bytes, excluding the byte in flight.
- `overflow_o`  out  1  sticky; set when a write is dropped because the FIFO is full.

## Operation

Storage:
- DEPTH x 8 register array.
- AW+1-bit write and read pointers wrap modulo 2^(AW+1).
- level = wr_ptr - rd_ptr.

Write:
- When `wr_i`=1 and not `full_o`: store `wdata_i` at wr_ptr[AW-1:0] and increment wr_ptr.
- When `wr_i`=1 and `full_o`=1: drop the byte, set `overflow_o`, leave pointers unchanged.
- `full_o` uses the current level, so a write while full is dropped even if a pop happens in the same cycle.

Launch FSM (states IDLE, WAIT_DONE):
- IDLE, not empty:
  - `tx_data_o` <= mem[rd_ptr]
  - rd_ptr increments
  - `send_o` <= 1
  - next state WAIT_DONE
- IDLE, empty: stay in IDLE. `end_char_tx_i` is ignored in IDLE.
- WAIT_DONE: `send_o` <= 0. On `end_char_tx_i`=1, go to IDLE; otherwise stay.

Outputs and side conditions:
- `send_o` is a registered output, high for exactly one cycle per byte.
- `tx_data_o` holds its value until the next launch.
- A simultaneous write and pop with the FIFO not full leaves level unchanged. Both operations take effect.
- `clear_i`:
  - sets rd_ptr to wr_ptr, so the FIFO is empty;
  - clears `overflow_o`;
  - does not abort the byte in flight; the FSM stays in its current state;
  - has priority over a `wr_i` in the same cycle, and that write is dropped without setting overflow.
- `idle_o` = `empty_o` & (state == IDLE).

Reset (asynchronous, active-high):
- Pointers = 0, state = IDLE.
- Outputs: `send_o`=0, `tx_data_o`=8'h00, `overflow_o`=0, `full_o`=0, `empty_o`=1, `idle_o`=1, `level_o`=0.
- Assertion mid-transmission discards the queue and the in-flight state. The transmitter shares `rst_i`, so no handshake is left dangling.

## Timing

- Write latency: `wr_i` sampled at edge k; `level_o`, `empty_o` and `full_o` update after edge k.
- Launch latency into an empty FIFO with the FSM in IDLE:
  - `wr_i` at edge k;
  - pop at edge k+1;
  - `send_o` high during the cycle after edge k+1, i.e. 2 cycles after the write.
- Back-to-back: with bytes queued, the next `send_o` is high in the second cycle after the cycle where `end_char_tx_i`=1. This is one IDLE cycle, which gives the transmitter's edge detector a low-then-high transition.
- The byte in flight has already been popped, so level drops at launch, not at stop-bit end.
- All outputs are registered except `full_o`, `empty_o`, `idle_o` and `level_o`, which are decoded combinationally from registers.
- No combinational path from any input to any output.

## Test plan

- Single byte: after reset, write 8'h41.
  - `send_o` is a single pulse 2 cycles later with `tx_data_o`=8'h41.
  - `idle_o` goes 0.
  - `end_char_tx_i` pulse returns `idle_o` to 1.
- Ordering: write 8'h01, 8'h02, 8'h03 on consecutive cycles.
  - Three `send_o` pulses carrying 01, 02, 03 in that order.
  - Each pulse comes only after the previous `end_char_tx_i`, spaced one IDLE cycle after it.
- Full/overflow: with `end_char_tx_i` held low, write 17 bytes 8'h10..8'h20.
  - 8'h10 is launched.
  - 8'h11..8'h20 fill the FIFO: level=16, `full_o`=1.
  - One further write sets `overflow_o`=1, level stays 16, and that byte never appears on `tx_data_o`.
- Simultaneous write and pop: level=3 with the FSM in IDLE, assert `wr_i` in the launch cycle.
  - Level stays 3.
  - The new byte is emitted after the existing ones.
- Clear: level=5 with a byte in flight, pulse `clear_i` together with `wr_i`.
  - Level=0, `overflow_o`=0.
  - The in-flight `tx_data_o` is unchanged.
  - After `end_char_tx_i`, no further `send_o` and `idle_o`=1.
- Async reset mid-WAIT_DONE: assert `rst_i` between clock edges.
  - All outputs go to reset values immediately, without waiting for a clock edge.
  - After release, a write of 8'h55 launches normally.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: transmit byte queue between the bus TX data register and the serial
// transmitter. Bus writes are buffered in a DEPTH-entry FIFO. A two-state launch FSM pops one byte,
// pulses send_o, and then waits for end_char_tx_i before it launches the next byte.
//
// Ports:
//   clk_i          system clock
//   rst_i          asynchronous active-high reset
//   wr_i, wdata_i  enqueue strobe and byte
//   clear_i        synchronous flush of queued bytes, also clears overflow_o
//   end_char_tx_i  stop-bit-complete pulse from the transmitter
//   send_o         one-cycle launch pulse (registered)
//   tx_data_o      byte in flight, held until the next launch (registered)
//   full_o, empty_o, idle_o, level_o  queue status, decoded from registers
//   overflow_o     sticky flag for a write dropped while full
module uart_tx_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          wr_i,
  input  logic [7:0]    wdata_i,
  input  logic          clear_i,
  input  logic          end_char_tx_i,
  output logic          send_o,
  output logic [7:0]    tx_data_o,
  output logic          full_o,
  output logic          empty_o,
  output logic          idle_o,
  output logic [AW:0]   level_o,
  output logic          overflow_o
);

  localparam logic [AW:0] DepthLvl = (AW+1)'(DEPTH);
  localparam logic [AW:0] PtrOne   = (AW+1)'(1);

  typedef enum logic [0:0] {StIdle, StWaitDone} state_e;

  state_e      state_q, state_d;
  logic [7:0]  mem_q [DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        send_q, send_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        overflow_q, overflow_d;
  logic        wr_en;
  logic        pop;

  // Status decode; the pointers carry one extra wrap bit so full and empty differ.
  assign level_o    = wr_ptr_q - rd_ptr_q;
  assign full_o     = (level_o == DepthLvl);
  assign empty_o    = (level_o == '0);
  assign idle_o     = empty_o && (state_q == StIdle);
  assign send_o     = send_q;
  assign tx_data_o  = tx_data_q;
  assign overflow_o = overflow_q;

  // Clear wins over a same-cycle write, and that write does not count as an overflow.
  assign wr_en = wr_i && !full_o && !clear_i;

  always_comb begin
    state_d    = state_q;
    send_d     = 1'b0;
    tx_data_d  = tx_data_q;
    pop        = 1'b0;
    unique case (state_q)
      StIdle: begin
        // A flush in this cycle empties the queue, so nothing may be launched.
        if (!empty_o && !clear_i) begin
          pop       = 1'b1;
          tx_data_d = mem_q[rd_ptr_q[AW-1:0]];
          send_d    = 1'b1;
          state_d   = StWaitDone;
        end
      end
      StWaitDone: begin
        if (end_char_tx_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    wr_ptr_d   = wr_en ? wr_ptr_q + PtrOne : wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    overflow_d = overflow_q;
    if (clear_i) begin
      rd_ptr_d   = wr_ptr_q;
      overflow_d = 1'b0;
    end else begin
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PtrOne;
      end
      if (wr_i && full_o) begin
        overflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      send_q     <= 1'b0;
      tx_data_q  <= 8'h00;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      send_q     <= send_d;
      tx_data_q  <= tx_data_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage needs no reset; slots are only read after they have been written.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr;
  logic [7:0] wdata;
  logic       clear;
  logic       end_char_tx;
  logic       send;
  logic [7:0] tx_data;
  logic       full;
  logic       empty;
  logic       idle;
  logic [4:0] level;
  logic       overflow;

  int checks = 0;
  int errors = 0;

  uart_tx_fifo #(
    .DEPTH(16),
    .AW   (4)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .wr_i         (wr),
    .wdata_i      (wdata),
    .clear_i      (clear),
    .end_char_tx_i(end_char_tx),
    .send_o       (send),
    .tx_data_o    (tx_data),
    .full_o       (full),
    .empty_o      (empty),
    .idle_o       (idle),
    .level_o      (level),
    .overflow_o   (overflow)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic write_byte(input logic [7:0] b);
    wr    = 1'b1;
    wdata = b;
    tick();
    wr    = 1'b0;
  endtask

  // End the byte in flight; expect one IDLE cycle, then the launch of exp.
  task automatic next_char(input logic [7:0] exp, input string tag);
    end_char_tx = 1'b1;
    tick();
    end_char_tx = 1'b0;
    check({tag, "_gap"}, send, 1'b0);
    tick();
    check({tag, "_send"}, send, 1'b1);
    check({tag, "_data"}, tx_data, exp);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_send"}, send, 1'b0);
    check({tag, "_tx"}, tx_data, 8'h00);
    check({tag, "_ovf"}, overflow, 1'b0);
    check({tag, "_full"}, full, 1'b0);
    check({tag, "_empty"}, empty, 1'b1);
    check({tag, "_idle"}, idle, 1'b1);
    check({tag, "_level"}, level, 5'd0);
  endtask

  initial begin
    rst = 1'b1; wr = 1'b0; wdata = 8'h00; clear = 1'b0; end_char_tx = 1'b0;
    tick();
    tick();
    check_reset_outputs("rst");
    rst = 1'b0;
    tick();

    // Single byte: launch 2 cycles after the write.
    write_byte(8'h41);
    check("s_level1", level, 5'd1);
    check("s_idle0", idle, 1'b0);
    check("s_nosend", send, 1'b0);
    tick();
    check("s_send", send, 1'b1);
    check("s_data", tx_data, 8'h41);
    check("s_level0", level, 5'd0);
    check("s_busy", idle, 1'b0);
    tick();
    check("s_pulse1", send, 1'b0);
    tick();
    check("s_wait", idle, 1'b0);
    end_char_tx = 1'b1;
    tick();
    end_char_tx = 1'b0;
    check("s_idle1", idle, 1'b1);
    tick();
    check("s_nosend2", send, 1'b0);

    // Ordering: three back-to-back writes.
    wr = 1'b1; wdata = 8'h01;
    tick();
    wdata = 8'h02;
    tick();
    check("o_send1", send, 1'b1);
    check("o_data1", tx_data, 8'h01);
    wdata = 8'h03;
    tick();
    wr = 1'b0;
    check("o_level2", level, 5'd2);
    check("o_pulse", send, 1'b0);
    tick();
    check("o_hold", send, 1'b0);
    check("o_hold_data", tx_data, 8'h01);
    next_char(8'h02, "o2");
    next_char(8'h03, "o3");
    end_char_tx = 1'b1;
    tick();
    end_char_tx = 1'b0;
    check("o_idle", idle, 1'b1);

    // Full/overflow: 17 writes with the transmitter stalled.
    for (int i = 0; i < 17; i++) begin
      write_byte(8'(8'h10 + i));
    end
    check("f_level16", level, 5'd16);
    check("f_full", full, 1'b1);
    check("f_inflight", tx_data, 8'h10);
    check("f_ovf0", overflow, 1'b0);
    write_byte(8'hAA);
    check("f_ovf1", overflow, 1'b1);
    check("f_level_hold", level, 5'd16);
    for (int i = 1; i < 17; i++) begin
      next_char(8'(8'h10 + i), "f_drain");
    end
    check("f_empty", empty, 1'b1);

    // Simultaneous write and pop with level 3 in IDLE.
    write_byte(8'h31);
    write_byte(8'h32);
    write_byte(8'h33);
    end_char_tx = 1'b1;
    tick();
    end_char_tx = 1'b0;
    check("w_level3", level, 5'd3);
    check("w_idlecyc", send, 1'b0);
    write_byte(8'h34);
    check("w_level_same", level, 5'd3);
    check("w_send", send, 1'b1);
    check("w_data", tx_data, 8'h31);
    next_char(8'h32, "w2");
    next_char(8'h33, "w3");
    next_char(8'h34, "w4");

    // Clear with a byte in flight and a same-cycle write.
    for (int i = 0; i < 5; i++) begin
      write_byte(8'(8'h41 + i));
    end
    check("c_level5", level, 5'd5);
    check("c_ovf_sticky", overflow, 1'b1);
    clear = 1'b1; wr = 1'b1; wdata = 8'h46;
    tick();
    clear = 1'b0; wr = 1'b0;
    check("c_level0", level, 5'd0);
    check("c_ovf0", overflow, 1'b0);
    check("c_tx_kept", tx_data, 8'h34);
    check("c_busy", idle, 1'b0);
    end_char_tx = 1'b1;
    tick();
    end_char_tx = 1'b0;
    check("c_idle", idle, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("c_nosend", send, 1'b0);
    end

    // Asynchronous reset while waiting for the stop bit.
    write_byte(8'h77);
    write_byte(8'h78);
    check("r_send", send, 1'b1);
    check("r_data", tx_data, 8'h77);
    check("r_level1", level, 5'd1);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("r_async");
    tick();
    rst = 1'b0;
    tick();
    write_byte(8'h55);
    check("r_nosend", send, 1'b0);
    tick();
    check("r_send55", send, 1'b1);
    check("r_data55", tx_data, 8'h55);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
